timing_gen_multi: RTL and testbench

Parametrised successor to the drive timing generator. It divides the master clock into the following signals:
- a two-phase bit-cell timing chain: clock and data phases, each with a 1-cycle read enable and a shaped pulse;
- a 1 µs enable;
- a new 1 ms enable.

---
 rtl/timing_gen_multi.sv | 157 +++++++++++++++
 tb/tb_timing_gen_multi.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/timing_gen_multi.sv
// timing_gen_multi
// Master-clock divider for the drive emulation logic. It produces two things:
//   - a two-phase bit-cell chain (clock phase, then data phase), where each
//     phase has a 1-cycle read enable near its end and a shaped pulse at its
//     start; two bit rates can be selected at runtime, and the chain has a
//     resync input and a run gate;
//   - a free-running 1 us / 1 ms enable chain that ignores run, resync and
//     rate_sel.
// Every output is registered.
module timing_gen_multi #(
    parameter int HALF_A   = 28,
    parameter int HALF_B   = 40,
    parameter int PULSE_W  = 16,
    parameter int USEC_DIV = 40,
    parameter int MSEC_DIV = 1000,
    parameter int CW       = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic rate_sel,
    input  logic resync,
    input  logic run,
    output logic clkenbl_read_bit,
    output logic clkenbl_read_data,
    output logic clock_pulse,
    output logic data_pulse,
    output logic data_phase,
    output logic clkenbl_1usec,
    output logic clkenbl_1msec
);

    localparam int UW = $clog2(USEC_DIV + 1);
    localparam int MW = $clog2(MSEC_DIV + 1);

    localparam logic [CW-1:0] HALF_A_C   = CW'(HALF_A);
    localparam logic [CW-1:0] HALF_B_C   = CW'(HALF_B);
    localparam logic [CW-1:0] PULSE_W_C  = CW'(PULSE_W);
    localparam logic [CW-1:0] CNT_ONE_C  = CW'(1);
    localparam logic [CW-1:0] CNT_TWO_C  = CW'(2);
    localparam logic [UW-1:0] USEC_DIV_C = UW'(USEC_DIV);
    localparam logic [UW-1:0] USEC_ONE_C = UW'(1);
    localparam logic [MW-1:0] MSEC_DIV_C = MW'(MSEC_DIV);
    localparam logic [MW-1:0] MSEC_ONE_C = MW'(1);

    // Bit-chain state. phase_r resets to the data phase, so the first load
    // after reset or resync opens a clock phase.
    logic [CW-1:0] half_cnt_r;
    logic [CW-1:0] n_act_r;
    logic          phase_r;

    logic [UW-1:0] usec_cnt_r;
    logic [MW-1:0] msec_cnt_r;

    logic [CW-1:0] n_next_s;
    logic [CW-1:0] half_nxt_s;
    logic [CW-1:0] n_act_nxt_s;
    logic          phase_nxt_s;
    logic          read_pt_s;
    logic          pulse_win_s;
    logic          read_bit_nxt_s;
    logic          read_data_nxt_s;
    logic          clock_pulse_nxt_s;
    logic          data_pulse_nxt_s;
    logic          usec_tick_s;
    logic          msec_tick_s;

    // Pick the rate for the next phase and decode the read and pulse windows.
    // A phase is never shortened: N_act is always >= PULSE_W + 2, so the
    // subtraction below cannot wrap.
    always_comb begin
        n_next_s    = rate_sel ? HALF_B_C : HALF_A_C;
        read_pt_s   = (half_cnt_r == CNT_TWO_C);
        pulse_win_s = (half_cnt_r > (n_act_r - PULSE_W_C));
        usec_tick_s = (usec_cnt_r == USEC_ONE_C);
        msec_tick_s = usec_tick_s & (msec_cnt_r == MSEC_ONE_C);
    end

    // Next-state and next-output logic for the bit chain. resync takes
    // priority over run, and a held chain forces the bit outputs low.
    always_comb begin
        half_nxt_s        = half_cnt_r;
        n_act_nxt_s       = n_act_r;
        phase_nxt_s       = phase_r;
        read_bit_nxt_s    = 1'b0;
        read_data_nxt_s   = 1'b0;
        clock_pulse_nxt_s = 1'b0;
        data_pulse_nxt_s  = 1'b0;
        if (resync) begin
            half_nxt_s  = CNT_ONE_C;
            phase_nxt_s = 1'b1;
        end else if (run) begin
            if (half_cnt_r == CNT_ONE_C) begin
                half_nxt_s  = n_next_s;
                n_act_nxt_s = n_next_s;
                phase_nxt_s = ~phase_r;
            end else begin
                half_nxt_s = half_cnt_r - CNT_ONE_C;
            end
            read_bit_nxt_s    = read_pt_s & ~phase_r;
            read_data_nxt_s   = read_pt_s & phase_r;
            clock_pulse_nxt_s = pulse_win_s & ~phase_r;
            data_pulse_nxt_s  = pulse_win_s & phase_r;
        end else begin
            half_nxt_s  = half_cnt_r;
            phase_nxt_s = phase_r;
        end
    end

    // Bit-chain registers and registered bit outputs. The data_phase output
    // reads 0 while in reset and then tracks the phase register.
    always_ff @(posedge clock) begin
        if (reset) begin
            half_cnt_r        <= CNT_ONE_C;
            n_act_r           <= HALF_A_C;
            phase_r           <= 1'b1;
            data_phase        <= 1'b0;
            clkenbl_read_bit  <= 1'b0;
            clkenbl_read_data <= 1'b0;
            clock_pulse       <= 1'b0;
            data_pulse        <= 1'b0;
        end else begin
            half_cnt_r        <= half_nxt_s;
            n_act_r           <= n_act_nxt_s;
            phase_r           <= phase_nxt_s;
            data_phase        <= phase_nxt_s;
            clkenbl_read_bit  <= read_bit_nxt_s;
            clkenbl_read_data <= read_data_nxt_s;
            clock_pulse       <= clock_pulse_nxt_s;
            data_pulse        <= data_pulse_nxt_s;
        end
    end

    // Free-running us/ms divider. The ms counter only moves on a us tick.
    always_ff @(posedge clock) begin
        if (reset) begin
            usec_cnt_r    <= USEC_DIV_C;
            msec_cnt_r    <= MSEC_DIV_C;
            clkenbl_1usec <= 1'b0;
            clkenbl_1msec <= 1'b0;
        end else begin
            if (usec_tick_s) begin
                usec_cnt_r <= USEC_DIV_C;
                if (msec_cnt_r == MSEC_ONE_C) begin
                    msec_cnt_r <= MSEC_DIV_C;
                end else begin
                    msec_cnt_r <= msec_cnt_r - MSEC_ONE_C;
                end
            end else begin
                usec_cnt_r <= usec_cnt_r - USEC_ONE_C;
                msec_cnt_r <= msec_cnt_r;
            end
            clkenbl_1usec <= usec_tick_s;
            clkenbl_1msec <= msec_tick_s;
        end
    end

endmodule

// File: tb/tb_timing_gen_multi.sv
`timescale 1ns/1ps
// Testbench for timing_gen_multi. It runs these stages:
//   - table-driven checks of the default sequence after reset;
//   - hand-written sequences for a rate change, resync, the run gate and a
//     mid-operation reset;
//   - a long randomized run compared cycle by cycle against a behavioural
//     model that tracks each phase position and the time since reset.
module tb_timing_gen_multi;

    localparam int HA = 28;
    localparam int HB = 40;
    localparam int PW = 16;
    localparam int UD = 40;
    localparam int MD = 1000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic rate_sel = 1'b0;
    logic resync = 1'b0;
    logic run = 1'b1;
    logic clkenbl_read_bit, clkenbl_read_data, clock_pulse, data_pulse;
    logic data_phase, clkenbl_1usec, clkenbl_1msec;

    int checks = 0;
    int passes = 0;

    timing_gen_multi #(
        .HALF_A(HA), .HALF_B(HB), .PULSE_W(PW),
        .USEC_DIV(UD), .MSEC_DIV(MD), .CW(8)
    ) dut (
        .clock(clock), .reset(reset), .rate_sel(rate_sel), .resync(resync), .run(run),
        .clkenbl_read_bit(clkenbl_read_bit), .clkenbl_read_data(clkenbl_read_data),
        .clock_pulse(clock_pulse), .data_pulse(data_pulse), .data_phase(data_phase),
        .clkenbl_1usec(clkenbl_1usec), .clkenbl_1msec(clkenbl_1msec)
    );

    always #5 clock = ~clock;

    // Output vector order: {read_bit, read_data, clock_pulse, data_pulse, data_phase, 1usec, 1msec}
    wire [6:0] outv = {clkenbl_read_bit, clkenbl_read_data, clock_pulse, data_pulse,
                       data_phase, clkenbl_1usec, clkenbl_1msec};

    // Reference model: each phase has a length and a position counted from its
    // start. The us/ms enables are derived from the number of edges since reset.
    int       m_t    = 0;
    bit       m_wait = 1'b1;
    bit       m_ph   = 1'b1;
    int       m_pos  = 0;
    int       m_len  = HA;
    logic [6:0] m_out = 7'd0;

    task automatic model_edge();
        bit rb, rd, cp, dl;
        rb = 1'b0; rd = 1'b0; cp = 1'b0; dl = 1'b0;
        if (reset) begin
            m_t = 0; m_wait = 1'b1; m_ph = 1'b1; m_pos = 0; m_len = HA;
            m_out = 7'd0;
        end else begin
            m_t++;
            if (resync) begin
                m_wait = 1'b1;
                m_ph   = 1'b1;
            end else if (run) begin
                if (m_wait) begin
                    m_wait = 1'b0;
                    m_ph   = 1'b0;
                    m_len  = rate_sel ? HB : HA;
                    m_pos  = 0;
                end else begin
                    rb = (m_pos == m_len - 2) && !m_ph;
                    rd = (m_pos == m_len - 2) && m_ph;
                    cp = (m_pos < PW) && !m_ph;
                    dl = (m_pos < PW) && m_ph;
                    m_pos++;
                    if (m_pos == m_len) begin
                        m_pos = 0;
                        m_ph  = !m_ph;
                        m_len = rate_sel ? HB : HA;
                    end
                end
            end
            m_out = {rb, rd, cp, dl, m_ph, (m_t % UD) == 0, (m_t % (UD * MD)) == 0};
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic check_vec(input string name, input int e, input logic [6:0] exp);
        checks++;
        if (outv === exp) passes++;
        else $display("FAIL %s edge %0d: got %b expected %b", name, e, outv, exp);
    endtask

    task automatic check_bit(input string name, input int e, input logic got, input logic exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s edge %0d: got %b expected %b", name, e, got, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1; resync = 1'b0; run = 1'b1; rate_sel = 1'b0;
        step();
        check_vec("reset_zero", 0, 7'b0000000);
        reset = 1'b0;
    endtask

    typedef struct {
        int         edge_n;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic run_table(input string tag);
        int e;
        e = 0;
        foreach (tbl[i]) begin
            while (e < tbl[i].edge_n) begin
                step();
                e++;
            end
            check_vec(tag, e, tbl[i].exp);
        end
    endtask

    initial begin
        // Expected outputs after a given edge following reset (rate 0, run 1).
        tbl.push_back('{1,   7'b0000000});
        tbl.push_back('{2,   7'b0010000});
        tbl.push_back('{17,  7'b0010000});
        tbl.push_back('{18,  7'b0000000});
        tbl.push_back('{27,  7'b0000000});
        tbl.push_back('{28,  7'b1000000});
        tbl.push_back('{29,  7'b0000100});
        tbl.push_back('{30,  7'b0001100});
        tbl.push_back('{39,  7'b0001100});
        tbl.push_back('{40,  7'b0001110});
        tbl.push_back('{45,  7'b0001100});
        tbl.push_back('{46,  7'b0000100});
        tbl.push_back('{56,  7'b0100100});
        tbl.push_back('{57,  7'b0000000});
        tbl.push_back('{58,  7'b0010000});
        tbl.push_back('{80,  7'b0000010});
        tbl.push_back('{84,  7'b1000000});
        tbl.push_back('{112, 7'b0100100});

        // Default sequence from reset.
        do_reset();
        run_table("scn_default");

        // Rate change 0->1 mid clock phase.
        do_reset();
        for (int e = 1; e <= 150; e++) begin
            if (e == 10) rate_sel = 1'b1;
            step();
            if (e == 28)  check_bit("rate_rb28", e, clkenbl_read_bit, 1'b1);
            if (e == 45)  check_bit("rate_dp45", e, data_pulse, 1'b1);
            if (e == 46)  check_bit("rate_dp46", e, data_pulse, 1'b0);
            if (e == 56)  check_bit("rate_rd56", e, clkenbl_read_data, 1'b0);
            if (e == 68)  check_bit("rate_rd68", e, clkenbl_read_data, 1'b1);
            if (e == 107) check_bit("rate_rb107", e, clkenbl_read_bit, 1'b0);
            if (e == 108) check_bit("rate_rb108", e, clkenbl_read_bit, 1'b1);
            if (e == 148) check_bit("rate_rd148", e, clkenbl_read_data, 1'b1);
        end

        // One-cycle resync at edge 100.
        do_reset();
        for (int e = 1; e <= 130; e++) begin
            resync = (e == 100);
            step();
            if (e == 99)  check_bit("rsy_dp99", e, data_pulse, 1'b1);
            if (e == 100) check_vec("rsy_at100", e, 7'b0000100);
            if (e == 102) check_bit("rsy_cp102", e, clock_pulse, 1'b1);
            if (e == 120) check_bit("rsy_us120", e, clkenbl_1usec, 1'b1);
            if (e == 127) check_bit("rsy_rb127", e, clkenbl_read_bit, 1'b0);
            if (e == 128) check_bit("rsy_rb128", e, clkenbl_read_bit, 1'b1);
        end
        resync = 1'b0;

        // run low for 10 cycles while half_cnt = 15 in the clock phase.
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            run = !(e >= 15 && e <= 24);
            step();
            if (e == 14) check_bit("run_cp14", e, clock_pulse, 1'b1);
            if (e == 15) check_bit("run_cp15", e, clock_pulse, 1'b0);
            if (e == 24) check_bit("run_cp24", e, clock_pulse, 1'b0);
            if (e == 25) check_bit("run_cp25", e, clock_pulse, 1'b1);
            if (e == 27) check_bit("run_cp27", e, clock_pulse, 1'b1);
            if (e == 28) check_vec("run_at28", e, 7'b0000000);
            if (e == 38) check_bit("run_rb38", e, clkenbl_read_bit, 1'b1);
        end
        run = 1'b1;

        // Reset mid data phase, then the default sequence must repeat exactly.
        do_reset();
        for (int e = 1; e <= 40; e++) step();
        do_reset();
        run_table("scn_after_reset");

        // Randomized run against the model; long enough to cover a ms enable.
        do_reset();
        for (int e = 1; e <= 41000; e++) begin
            run    = ($urandom_range(0, 19) != 0);
            resync = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 99) == 0) rate_sel = ~rate_sel;
            step();
            check_vec("random", e, m_out);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
